hdpldadapt_rx_datapath_insert_nw: RTL and testbench

Parametrised read-side rate-match insertion engine for the RX adapter's 10GBASE-R-class datapath. It sits between the RX elastic FIFO read port and the PLD-side output register. When the FIFO runs partially empty, it inserts idle columns at an idle or ordered-set boundary. The datapath carries NWORD 32-bit XGMII columns per beat. The engine supports split-beat insertion at any column, bounded back-to-back insertion, underrun error signalling and an insertion counter.

---
 rtl/hdpldadapt_xgmii_pkg.sv | 34 +++
 rtl/hdpldadapt_rx_datapath_insert_nw_if.sv | 29 ++
 rtl/hdpldadapt_rx_insert_col_sel.sv | 31 +++
 rtl/hdpldadapt_rx_datapath_insert_nw.sv | 179 +++++++++++++++++
 tb/tb_hdpldadapt_rx_datapath_insert_nw.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdpldadapt_xgmii_pkg.sv
// Shared XGMII constants, column-eligibility helper and FSM state encoding
// for the RX rate-match insertion engine.
package hdpldadapt_xgmii_pkg;

  // XGMII control characters
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_SEQOS = 8'h9C;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  // Flag bit offsets above the per-byte control bits
  localparam int CTL_ERR_OFS = 0;
  localparam int CTL_BFL_OFS = 1;

  // Per-column words: local fault ordered set, idle column, error column
  localparam logic [31:0] COL_LF_WORD   = 32'h0100_009C;
  localparam logic [3:0]  COL_LF_CTRL   = 4'h1;
  localparam logic [31:0] COL_IDLE_WORD = {4{XGMII_IDLE}};
  localparam logic [3:0]  COL_IDLE_CTRL = 4'hF;
  localparam logic [31:0] COL_ERR_WORD  = {4{XGMII_ERROR}};
  localparam logic [3:0]  COL_ERR_CTRL  = 4'hF;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SPLIT = 3'd2
  } state_t;

  // A column can host an insertion boundary if it is idle or an ordered set
  function automatic logic col_eligible(input logic [31:0] word, input logic [3:0] ctrl);
    return ((word == COL_IDLE_WORD) && (ctrl == COL_IDLE_CTRL)) ||
           ((word[7:0] == XGMII_SEQOS) && (ctrl == 4'h1));
  endfunction

endpackage

// File: rtl/hdpldadapt_rx_datapath_insert_nw_if.sv
// FIFO-read / PLD-output bundle between the elastic FIFO, the insertion
// engine and the downstream output consumer.
interface hdpldadapt_rx_datapath_insert_nw_if #(
  parameter int NWORD = 2
);
  localparam int DW = 32 * NWORD;
  localparam int CW = 4 * NWORD + 2;

  logic [DW+CW-1:0] fifo_data;
  logic             fifo_pempty;
  logic             fifo_empty;
  logic             data_valid;
  logic             rd_en;
  logic [CW-1:0]    dout_ctrl;
  logic [DW-1:0]    dout_data;
  logic             dout_valid;

  // Side that supplies the FIFO head and observes the engine output
  modport master (
    output fifo_data, fifo_pempty, fifo_empty, data_valid,
    input  rd_en, dout_ctrl, dout_data, dout_valid
  );

  // Insertion engine side
  modport slave (
    input  fifo_data, fifo_pempty, fifo_empty, data_valid,
    output rd_en, dout_ctrl, dout_data, dout_valid
  );
endinterface

// File: rtl/hdpldadapt_rx_insert_col_sel.sv
// Per-column insertion eligibility and lowest-index priority encoder.
module hdpldadapt_rx_insert_col_sel
  import hdpldadapt_xgmii_pkg::*;
#(
  parameter int NWORD = 2
) (
  input  logic [32*NWORD-1:0] data,
  input  logic [4*NWORD-1:0]  ctrl,
  output logic [2:0]          col_k,
  output logic                any_elig
);

  logic [NWORD-1:0] elig;

  generate
    for (genvar gi = 0; gi < NWORD; gi++) begin : g_elig
      assign elig[gi] = col_eligible(data[32*gi +: 32], ctrl[4*gi +: 4]);
    end
  endgenerate

  // Scan from the top column down so the last hit is the lowest index
  always_comb begin
    col_k = 3'd0;
    for (int c = NWORD - 1; c >= 0; c--) begin
      if (elig[c]) col_k = 3'(c);
    end
  end

  assign any_elig = |elig;

endmodule

// File: rtl/hdpldadapt_rx_datapath_insert_nw.sv
// Read-side rate-match insertion engine: when the elastic FIFO runs
// partially empty, splits the head beat at its first idle/OS column and
// injects idle columns (optionally extra all-idle beats) before it.
module hdpldadapt_rx_datapath_insert_nw
  import hdpldadapt_xgmii_pkg::*;
#(
  parameter int NWORD = 2
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  hdpldadapt_rx_datapath_insert_nw_if.slave bus,
  input  logic        r_truebac2bac,
  input  logic [3:0]  r_max_insert,
  output logic        rd_en_lt,
  output logic        fifo_insert,
  output logic        underrun,
  output logic [15:0] insert_cnt,
  output logic [19:0] testbus
);

  localparam int DW      = 32 * NWORD;
  localparam int CW      = 4 * NWORD + 2;
  localparam int NB      = 4 * NWORD;
  localparam int CTL_ERR = NB + CTL_ERR_OFS;
  localparam int CTL_BFL = NB + CTL_BFL_OFS;

  localparam logic [DW-1:0] LF_DATA   = {NWORD{COL_LF_WORD}};
  localparam logic [CW-1:0] LF_CTRL   = {2'b00, {NWORD{COL_LF_CTRL}}};
  localparam logic [DW-1:0] IDLE_DATA = {NWORD{COL_IDLE_WORD}};
  localparam logic [CW-1:0] IDLE_CTRL = {2'b00, {NWORD{COL_IDLE_CTRL}}};
  localparam logic [DW-1:0] ERR_DATA  = {NWORD{COL_ERR_WORD}};

  logic [DW-1:0] head_data;
  logic [CW-1:0] head_ctrl;
  logic [2:0]    col_k;
  logic          any_elig;

  state_t        state_reg, state_next;
  logic [2:0]    k_reg, k_next;
  logic [3:0]    burst_reg, burst_next;
  logic [DW-1:0] dout_data_reg, dout_data_next;
  logic [CW-1:0] dout_ctrl_reg, dout_ctrl_next;
  logic          dout_valid_reg;
  logic          fifo_insert_reg;
  logic          underrun_reg;
  logic          rd_en_sticky_reg;
  logic [15:0]   insert_cnt_reg;
  logic          rd_en_c;
  logic          insert_c;
  logic          underrun_set;
  logic          rd_en;

  assign head_data = bus.fifo_data[DW-1:0];
  assign head_ctrl = bus.fifo_data[DW+CW-1:DW];

  hdpldadapt_rx_insert_col_sel #(.NWORD(NWORD)) u_col_sel (
    .data     (head_data),
    .ctrl     (head_ctrl[NB-1:0]),
    .col_k    (col_k),
    .any_elig (any_elig)
  );

  // Next-state, consume, insert and output-beat selection
  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    burst_next     = burst_reg;
    dout_data_next = dout_data_reg;
    dout_ctrl_next = dout_ctrl_reg;
    rd_en_c        = 1'b0;
    insert_c       = 1'b0;
    underrun_set   = 1'b0;
    if (bus.data_valid) begin
      unique case (state_reg)
        ST_INIT: begin
          dout_data_next = LF_DATA;
          dout_ctrl_next = LF_CTRL;
          if (!bus.fifo_pempty) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (bus.fifo_empty) begin
            dout_data_next          = ERR_DATA;
            dout_ctrl_next          = '0;
            dout_ctrl_next[NB-1:0]  = '1;
            dout_ctrl_next[CTL_ERR] = 1'b1;
            underrun_set            = 1'b1;
            insert_c                = 1'b1;
          end else if (bus.fifo_pempty && any_elig) begin
            // beat1: head columns below k, idle from k upward, flags cleared
            dout_ctrl_next = '0;
            for (int c = 0; c < NWORD; c++) begin
              if (3'(c) < col_k) begin
                dout_data_next[32*c +: 32] = head_data[32*c +: 32];
                dout_ctrl_next[4*c +: 4]   = head_ctrl[4*c +: 4];
              end else begin
                dout_data_next[32*c +: 32] = COL_IDLE_WORD;
                dout_ctrl_next[4*c +: 4]   = COL_IDLE_CTRL;
              end
            end
            k_next     = col_k;
            burst_next = 4'd0;
            insert_c   = 1'b1;
            state_next = ST_SPLIT;
          end else begin
            rd_en_c        = 1'b1;
            dout_data_next = head_data;
            dout_ctrl_next = head_ctrl;
          end
        end
        ST_SPLIT: begin
          if (r_truebac2bac && bus.fifo_pempty && (burst_reg < r_max_insert)) begin
            dout_data_next = IDLE_DATA;
            dout_ctrl_next = IDLE_CTRL;
            burst_next     = burst_reg + 4'd1;
            insert_c       = 1'b1;
          end else begin
            // beat2: idle below the latched k, head from k upward, head flags kept
            dout_ctrl_next          = '0;
            dout_ctrl_next[CTL_ERR] = head_ctrl[CTL_ERR];
            dout_ctrl_next[CTL_BFL] = head_ctrl[CTL_BFL];
            for (int c = 0; c < NWORD; c++) begin
              if (3'(c) < k_reg) begin
                dout_data_next[32*c +: 32] = COL_IDLE_WORD;
                dout_ctrl_next[4*c +: 4]   = COL_IDLE_CTRL;
              end else begin
                dout_data_next[32*c +: 32] = head_data[32*c +: 32];
                dout_ctrl_next[4*c +: 4]   = head_ctrl[4*c +: 4];
              end
            end
            rd_en_c    = 1'b1;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  // State, output register and status counters
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg        <= ST_INIT;
      k_reg            <= 3'd0;
      burst_reg        <= 4'd0;
      dout_data_reg    <= LF_DATA;
      dout_ctrl_reg    <= LF_CTRL;
      dout_valid_reg   <= 1'b0;
      fifo_insert_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
      rd_en_sticky_reg <= 1'b0;
      insert_cnt_reg   <= 16'd0;
    end else begin
      state_reg        <= state_next;
      k_reg            <= k_next;
      burst_reg        <= burst_next;
      dout_data_reg    <= dout_data_next;
      dout_ctrl_reg    <= dout_ctrl_next;
      dout_valid_reg   <= bus.data_valid;
      fifo_insert_reg  <= insert_c;
      underrun_reg     <= underrun_reg | underrun_set;
      rd_en_sticky_reg <= rd_en_sticky_reg | rd_en;
      if (insert_c && (insert_cnt_reg != 16'hFFFF)) begin
        insert_cnt_reg <= insert_cnt_reg + 16'd1;
      end
    end
  end

  assign rd_en          = rd_en_c & ~rd_rst;
  assign bus.rd_en      = rd_en;
  assign bus.dout_data  = dout_data_reg;
  assign bus.dout_ctrl  = dout_ctrl_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign rd_en_lt       = rd_en | rd_en_sticky_reg;
  assign fifo_insert    = fifo_insert_reg;
  assign underrun       = underrun_reg;
  assign insert_cnt     = insert_cnt_reg;
  assign testbus        = {8'd0, burst_reg, col_k, state_reg, rd_en, underrun_reg};

endmodule

// File: tb/tb_hdpldadapt_rx_datapath_insert_nw.sv
// Directed bench for the insertion engine at NWORD=4.
module tb_hdpldadapt_rx_datapath_insert_nw;

  localparam int NWORD = 4;

  localparam logic [31:0] IDLE_W = 32'h0707_0707;
  localparam logic [31:0] LF_W   = 32'h0100_009C;
  localparam logic [31:0] ERR_W  = 32'hFEFE_FEFE;
  localparam logic [31:0] OS_W   = 32'h0200_009C;

  logic        rd_clk;
  logic        rd_rst;
  logic        r_truebac2bac;
  logic [3:0]  r_max_insert;
  logic        rd_en_lt;
  logic        fifo_insert;
  logic        underrun;
  logic [15:0] insert_cnt;
  logic [19:0] testbus;

  int checks   = 0;
  int failures = 0;

  hdpldadapt_rx_datapath_insert_nw_if #(.NWORD(NWORD)) bus ();

  hdpldadapt_rx_datapath_insert_nw #(.NWORD(NWORD)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .bus           (bus),
    .r_truebac2bac (r_truebac2bac),
    .r_max_insert  (r_max_insert),
    .rd_en_lt      (rd_en_lt),
    .fifo_insert   (fifo_insert),
    .underrun      (underrun),
    .insert_cnt    (insert_cnt),
    .testbus       (testbus)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // {BFL, ERR, ctrl3..ctrl0, word3..word0}
  function automatic logic [145:0] beat(input logic [31:0] w3, w2, w1, w0,
                                        input logic [3:0] c3, c2, c1, c0,
                                        input logic err, bfl);
    return {bfl, err, c3, c2, c1, c0, w3, w2, w1, w0};
  endfunction

  // Non-eligible streaming beat (ctrl all zero)
  function automatic logic [145:0] sbeat(input int i);
    logic [31:0] b;
    b = 32'hC0DE_0000 | (32'(i) << 8);
    return beat(b | 32'd3, b | 32'd2, b | 32'd1, b, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'(i));
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  function automatic logic [145:0] dout();
    return {bus.dout_ctrl, bus.dout_data};
  endfunction

  logic [145:0] lf_beat, h_split, b1_split, b2_split;
  logic [145:0] h_b2b, b1_b2b, idle_beat, b2_b2b, err_beat;

  initial begin
    lf_beat   = beat(LF_W, LF_W, LF_W, LF_W, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
    h_split   = beat(32'h7788_99AB, IDLE_W, 32'h4455_6601, 32'h1122_3300,
                     4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
    b1_split  = beat(IDLE_W, IDLE_W, 32'h4455_6601, 32'h1122_3300,
                     4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    b2_split  = beat(32'h7788_99AB, IDLE_W, IDLE_W, IDLE_W,
                     4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1);
    h_b2b     = beat(32'h9ABC_DEF0, 32'h1234_5678, OS_W, 32'h0000_AA00,
                     4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
    b1_b2b    = beat(IDLE_W, IDLE_W, IDLE_W, 32'h0000_AA00,
                     4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    idle_beat = beat(IDLE_W, IDLE_W, IDLE_W, IDLE_W, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    b2_b2b    = beat(32'h9ABC_DEF0, 32'h1234_5678, OS_W, IDLE_W,
                     4'h0, 4'h0, 4'h1, 4'hF, 1'b1, 1'b0);
    err_beat  = beat(ERR_W, ERR_W, ERR_W, ERR_W, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);

    // ---- reset state
    rd_rst          = 1'b1;
    bus.fifo_data   = '0;
    bus.fifo_pempty = 1'b0;
    bus.fifo_empty  = 1'b0;
    bus.data_valid  = 1'b1;
    r_truebac2bac   = 1'b0;
    r_max_insert    = 4'd0;
    tick();
    tick();
    chk("rst_dout", dout(), lf_beat);
    chk("rst_dout_valid", bus.dout_valid, 1'b0);
    chk("rst_rd_en", bus.rd_en, 1'b0);
    chk("rst_rd_en_lt", rd_en_lt, 1'b0);
    chk("rst_fifo_insert", fifo_insert, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_insert_cnt", insert_cnt, 16'd0);
    chk("rst_testbus", testbus, 20'd0);

    // ---- INIT holds while pempty
    bus.fifo_pempty = 1'b1;
    rd_rst = 1'b0;
    tick();
    tick();
    chk("init_state", testbus[4:2], 3'd0);
    chk("init_dout", dout(), lf_beat);
    chk("init_dout_valid", bus.dout_valid, 1'b1);

    // ---- pass-through stream
    bus.fifo_pempty = 1'b0;
    bus.fifo_data   = sbeat(0);
    #1;
    chk("init_rd_en", bus.rd_en, 1'b0);
    tick();
    chk("run_state", testbus[4:2], 3'd1);
    for (int i = 0; i < 10; i++) begin
      bus.fifo_data = sbeat(i);
      #1;
      chk($sformatf("stream_rd_en%0d", i), bus.rd_en, 1'b1);
      tick();
      chk($sformatf("stream_dout%0d", i), dout(), sbeat(i));
    end
    chk("stream_insert_cnt", insert_cnt, 16'd0);
    chk("stream_rd_en_lt", rd_en_lt, 1'b1);

    // ---- pempty with no eligible column never splits
    bus.fifo_pempty = 1'b1;
    bus.fifo_data   = sbeat(10);
    #1;
    chk("noelig_rd_en", bus.rd_en, 1'b1);
    tick();
    chk("noelig_dout", dout(), sbeat(10));
    chk("noelig_insert", fifo_insert, 1'b0);

    // ---- single split at column 2
    bus.fifo_data = h_split;
    #1;
    chk("split_colk", testbus[7:5], 3'd2);
    chk("split_rd_en1", bus.rd_en, 1'b0);
    tick();
    chk("split_beat1", dout(), b1_split);
    chk("split_insert1", fifo_insert, 1'b1);
    chk("split_cnt1", insert_cnt, 16'd1);
    chk("split_state", testbus[4:2], 3'd2);
    chk("split_rd_en2", bus.rd_en, 1'b1);
    tick();
    chk("split_beat2", dout(), b2_split);
    chk("split_insert2", fifo_insert, 1'b0);
    chk("split_state2", testbus[4:2], 3'd1);

    // ---- back-to-back: beat1, 3 idle beats, beat2 (k=1)
    r_truebac2bac = 1'b1;
    r_max_insert  = 4'd3;
    bus.fifo_data = h_b2b;
    tick();
    chk("b2b_beat1", dout(), b1_b2b);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b2b_rd_en_idle%0d", i), bus.rd_en, 1'b0);
      tick();
      chk($sformatf("b2b_idle%0d", i), dout(), idle_beat);
      chk($sformatf("b2b_insert%0d", i), fifo_insert, 1'b1);
    end
    chk("b2b_burst", testbus[11:8], 4'd3);
    chk("b2b_rd_en2", bus.rd_en, 1'b1);
    tick();
    chk("b2b_beat2", dout(), b2_b2b);
    chk("b2b_cnt", insert_cnt, 16'd5);

    // ---- data_valid toggling during SPLIT
    r_truebac2bac = 1'b0;
    bus.fifo_data = h_split;
    tick();
    chk("dv_beat1", dout(), b1_split);
    bus.data_valid = 1'b0;
    #1;
    chk("dv_rd_en_off", bus.rd_en, 1'b0);
    tick();
    chk("dv_hold1", dout(), b1_split);
    chk("dv_valid0", bus.dout_valid, 1'b0);
    chk("dv_insert0", fifo_insert, 1'b0);
    chk("dv_state_hold", testbus[4:2], 3'd2);
    bus.data_valid = 1'b1;
    #1;
    chk("dv_rd_en_on", bus.rd_en, 1'b1);
    tick();
    chk("dv_beat2", dout(), b2_split);
    chk("dv_valid1", bus.dout_valid, 1'b1);
    bus.data_valid  = 1'b0;
    bus.fifo_pempty = 1'b0;
    bus.fifo_data   = sbeat(11);
    tick();
    chk("dv_hold2", dout(), b2_split);
    chk("dv_state_run", testbus[4:2], 3'd1);
    chk("dv_cnt", insert_cnt, 16'd6);
    bus.data_valid = 1'b1;

    // ---- empty beats pempty: error beat, sticky underrun
    bus.fifo_empty  = 1'b1;
    bus.fifo_pempty = 1'b1;
    bus.fifo_data   = h_split;
    #1;
    chk("empty_rd_en", bus.rd_en, 1'b0);
    tick();
    chk("empty_dout", dout(), err_beat);
    chk("empty_underrun", underrun, 1'b1);
    chk("empty_insert", fifo_insert, 1'b1);
    chk("empty_cnt", insert_cnt, 16'd7);
    bus.fifo_empty  = 1'b0;
    bus.fifo_pempty = 1'b0;
    bus.fifo_data   = sbeat(12);
    tick();
    chk("after_empty_dout", dout(), sbeat(12));
    chk("underrun_sticky", underrun, 1'b1);

    // ---- reset during SPLIT
    bus.fifo_pempty = 1'b1;
    bus.fifo_data   = h_split;
    tick();
    chk("rsplit_beat1", dout(), b1_split);
    rd_rst = 1'b1;
    #1;
    chk("rsplit_dout", dout(), lf_beat);
    chk("rsplit_rd_en", bus.rd_en, 1'b0);
    chk("rsplit_rd_en_lt", rd_en_lt, 1'b0);
    chk("rsplit_underrun", underrun, 1'b0);
    chk("rsplit_cnt", insert_cnt, 16'd0);
    tick();
    rd_rst = 1'b0;
    tick();
    tick();
    chk("rsplit_init_state", testbus[4:2], 3'd0);
    chk("rsplit_init_rd_en", bus.rd_en, 1'b0);
    chk("rsplit_init_dout", dout(), lf_beat);
    bus.fifo_pempty = 1'b0;
    tick();
    chk("rsplit_run_state", testbus[4:2], 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
